// File: rtl/issue_scheduler.sv
// In-order issue scheduler: scoreboard, unit busy flags and stall counter.
// Decides same-cycle issue of one decoded instruction per clock.
module issue_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_dispatch_unit,
  input  logic [2:0]  in_rs_fpu,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rs3,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_fpu_reg_write,
  input  logic        flush,
  input  logic        lalu_done,
  input  logic        lfpu_done,
  input  logic        mem_done,
  input  logic        io_done,
  input  logic [4:0]  lalu_rd,
  input  logic [4:0]  lfpu_rd,
  input  logic [4:0]  mem_rd,
  input  logic        mem_fp,
  output logic        in_ready,
  output logic        issue_valid,
  output logic [3:0]  issue_unit,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] U_LALU  = 4'd2;
  localparam logic [3:0] U_LOAD  = 4'd4;
  localparam logic [3:0] U_STORE = 4'd5;
  localparam logic [3:0] U_LFPU  = 4'd7;
  localparam logic [3:0] U_IN    = 4'd8;
  localparam logic [3:0] U_OUT   = 4'd9;

  typedef enum logic {RUN, STALL} state_t;

  state_t      r_state;
  logic [63:0] r_pend;
  logic        r_lalu_busy;
  logic        r_lfpu_busy;
  logic        r_mem_busy;
  logic        r_io_busy;
  logic        r_io_wr;
  logic        r_io_fp;
  logic [4:0]  r_io_rd;

  logic        w_illegal;
  logic        w_struct;
  logic        w_raw;
  logic        w_waw;
  logic        w_hazard;
  logic        w_ready;
  logic        w_wr;
  logic        w_x0;
  logic        w_set_pend;
  logic [5:0]  w_set_idx;
  logic [63:0] w_pend_nxt;
  logic        w_lalu_nxt;
  logic        w_lfpu_nxt;
  logic        w_mem_nxt;
  logic        w_io_nxt;

  // Hazard detection and the same-cycle accept decision.
  always_comb begin
    w_illegal = (in_dispatch_unit >= 4'd10);
    w_struct  = 1'b0;
    case (in_dispatch_unit)
      U_LALU:  w_struct = r_lalu_busy;
      U_LOAD:  w_struct = r_mem_busy;
      U_STORE: w_struct = r_mem_busy;
      U_LFPU:  w_struct = r_lfpu_busy;
      U_IN:    w_struct = r_io_busy;
      U_OUT:   w_struct = r_io_busy;
      default: w_struct = 1'b0;
    endcase
    w_raw = r_pend[{in_rs_fpu[0], in_rs1}]
          | r_pend[{in_rs_fpu[1], in_rs2}]
          | (in_rs_fpu[2] & r_pend[{1'b1, in_rs3}]);
    w_waw = (in_reg_write & r_pend[{1'b0, in_rd}])
          | (in_fpu_reg_write & r_pend[{1'b1, in_rd}]);
    w_hazard = w_illegal | w_struct | w_raw | w_waw;
    w_ready  = ~rst & in_valid & ~w_hazard & ~flush;
  end

  assign in_ready    = w_ready;
  assign issue_valid = w_ready;
  assign issue_unit  = w_ready ? in_dispatch_unit : 4'd0;

  // Next scoreboard and busy state: completions clear, issue sets and wins.
  always_comb begin
    w_wr      = in_reg_write | in_fpu_reg_write;
    w_x0      = ~in_fpu_reg_write & (in_rd == 5'd0);
    w_set_idx = {in_fpu_reg_write, in_rd};
    w_set_pend = w_ready & ~w_x0 &
                 ((in_dispatch_unit == U_LALU) |
                  (in_dispatch_unit == U_LFPU) |
                  ((in_dispatch_unit == U_LOAD) & w_wr) |
                  ((in_dispatch_unit == U_IN) & w_wr));

    w_pend_nxt = r_pend;
    w_lalu_nxt = r_lalu_busy;
    w_lfpu_nxt = r_lfpu_busy;
    w_mem_nxt  = r_mem_busy;
    w_io_nxt   = r_io_busy;

    if (lalu_done && r_lalu_busy) begin
      w_pend_nxt[{1'b0, lalu_rd}] = 1'b0;
      w_lalu_nxt = 1'b0;
    end
    if (lfpu_done && r_lfpu_busy) begin
      w_pend_nxt[{1'b1, lfpu_rd}] = 1'b0;
      w_lfpu_nxt = 1'b0;
    end
    if (mem_done && r_mem_busy) begin
      w_pend_nxt[{mem_fp, mem_rd}] = 1'b0;
      w_mem_nxt = 1'b0;
    end
    if (io_done && r_io_busy) begin
      if (r_io_wr) begin
        w_pend_nxt[{r_io_fp, r_io_rd}] = 1'b0;
      end
      w_io_nxt = 1'b0;
    end

    if (w_set_pend) begin
      w_pend_nxt[w_set_idx] = 1'b1;
    end
    if (w_ready) begin
      case (in_dispatch_unit)
        U_LALU:  w_lalu_nxt = 1'b1;
        U_LFPU:  w_lfpu_nxt = 1'b1;
        U_LOAD:  w_mem_nxt  = 1'b1;
        U_STORE: w_mem_nxt  = 1'b1;
        U_IN:    w_io_nxt   = 1'b1;
        U_OUT:   w_io_nxt   = 1'b1;
        default: ;
      endcase
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Scoreboard, busy flags and the latched I/O destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 64'd0;
      r_lalu_busy <= 1'b0;
      r_lfpu_busy <= 1'b0;
      r_mem_busy  <= 1'b0;
      r_io_busy   <= 1'b0;
      r_io_wr     <= 1'b0;
      r_io_fp     <= 1'b0;
      r_io_rd     <= 5'd0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_lalu_busy <= w_lalu_nxt;
      r_lfpu_busy <= w_lfpu_nxt;
      r_mem_busy  <= w_mem_nxt;
      r_io_busy   <= w_io_nxt;
      if (w_ready && in_dispatch_unit == U_IN) begin
        r_io_wr <= w_wr & ~w_x0;
        r_io_fp <= in_fpu_reg_write;
        r_io_rd <= in_rd;
      end else if (w_ready && in_dispatch_unit == U_OUT) begin
        r_io_wr <= 1'b0;
      end
    end
  end

  // Observational RUN/STALL tracker and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      stall_cycles <= 32'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (in_valid && w_hazard && !flush) r_state <= STALL;
        end
        STALL: begin
          if (!in_valid || flush || !w_hazard) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
      if (in_valid && !flush && !w_ready &&
          stall_cycles != 32'hFFFF_FFFF) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hazards, completions,
// flush and reset behaviour with hand-computed expectations.
module tb_issue_scheduler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_dispatch_unit;
  logic [2:0]  in_rs_fpu;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rs3;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_fpu_reg_write;
  logic        flush;
  logic        lalu_done;
  logic        lfpu_done;
  logic        mem_done;
  logic        io_done;
  logic [4:0]  lalu_rd;
  logic [4:0]  lfpu_rd;
  logic [4:0]  mem_rd;
  logic        mem_fp;
  logic        in_ready;
  logic        issue_valid;
  logic [3:0]  issue_unit;
  logic [31:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;

  issue_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_dispatch_unit (in_dispatch_unit),
    .in_rs_fpu        (in_rs_fpu),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_rs3           (in_rs3),
    .in_rd            (in_rd),
    .in_reg_write     (in_reg_write),
    .in_fpu_reg_write (in_fpu_reg_write),
    .flush            (flush),
    .lalu_done        (lalu_done),
    .lfpu_done        (lfpu_done),
    .mem_done         (mem_done),
    .io_done          (io_done),
    .lalu_rd          (lalu_rd),
    .lfpu_rd          (lfpu_rd),
    .mem_rd           (mem_rd),
    .mem_fp           (mem_fp),
    .in_ready         (in_ready),
    .issue_valid      (issue_valid),
    .issue_unit       (issue_unit),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pres(input logic [3:0] u, input logic [2:0] rsf,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] r3, input logic [4:0] rd,
                      input logic rw, input logic fw);
    in_valid         = 1'b1;
    in_dispatch_unit = u;
    in_rs_fpu        = rsf;
    in_rs1           = r1;
    in_rs2           = r2;
    in_rs3           = r3;
    in_rd            = rd;
    in_reg_write     = rw;
    in_fpu_reg_write = fw;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    lalu_done = 1'b0;
    lfpu_done = 1'b0;
    mem_done  = 1'b0;
    io_done   = 1'b0;
    #1;
  endtask

  task automatic exp_issue(input string tag, input logic [3:0] u);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid"}, {31'd0, issue_valid}, 32'd1);
    chk({tag, "_unit"}, {28'd0, issue_unit}, {28'd0, u});
    cyc();
  endtask

  task automatic exp_stall_step(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_unit"}, {28'd0, issue_unit}, 32'd0);
    cyc();
    exp_stall++;
    chk({tag, "_cnt"}, stall_cycles, exp_stall);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    lalu_rd = 5'd0;
    lfpu_rd = 5'd0;
    mem_rd = 5'd0;
    mem_fp = 1'b0;
    idle();
    pres(4'd1, 3'b000, 5'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_unit", {28'd0, issue_unit}, 32'd0);
    cyc();
    cyc();
    chk("rst_stall", stall_cycles, 32'd0);
    rst = 1'b0;
    idle();

    // Long ALU RAW on x5
    pres(4'd2, 3'b000, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    exp_issue("lalu_iss", 4'd2);
    pres(4'd1, 3'b000, 5'd5, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);
    exp_stall_step("raw_s1");
    exp_stall_step("raw_s2");
    lalu_done = 1'b1;
    lalu_rd = 5'd5;
    #1;
    exp_stall_step("raw_nobyp");
    lalu_done = 1'b0;
    #1;
    chk("raw_len", stall_cycles, 32'd3);
    exp_issue("raw_iss", 4'd1);
    idle();

    // Back-to-back long FPU
    pres(4'd7, 3'b011, 5'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1);
    exp_issue("lfpu_iss1", 4'd7);
    pres(4'd7, 3'b011, 5'd0, 5'd0, 5'd0, 5'd2, 1'b0, 1'b1);
    exp_stall_step("lfpu_busy");
    lfpu_done = 1'b1;
    lfpu_rd = 5'd1;
    #1;
    exp_stall_step("lfpu_nobyp");
    lfpu_done = 1'b0;
    #1;
    exp_issue("lfpu_iss2", 4'd7);
    // rs3 only checked when flagged
    pres(4'd6, 3'b100, 5'd0, 5'd0, 5'd2, 5'd5, 1'b0, 1'b1);
    exp_stall_step("rs3_raw");
    pres(4'd6, 3'b000, 5'd0, 5'd0, 5'd2, 5'd5, 1'b0, 1'b1);
    exp_issue("rs3_off", 4'd6);
    idle();
    lfpu_done = 1'b1;
    lfpu_rd = 5'd2;
    cyc();
    idle();

    // Load to x0
    pres(4'd4, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    exp_issue("ld_x0", 4'd4);
    pres(4'd1, 3'b000, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    exp_issue("x0_noraw", 4'd1);
    pres(4'd4, 3'b000, 5'd0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    exp_stall_step("mem_busy");
    mem_done = 1'b1;
    mem_rd = 5'd0;
    mem_fp = 1'b0;
    #1;
    exp_stall_step("mem_nobyp");
    mem_done = 1'b0;
    #1;
    exp_issue("ld2_iss", 4'd4);
    idle();
    mem_done = 1'b1;
    mem_rd = 5'd8;
    cyc();
    idle();

    // File separation with flw f3
    pres(4'd4, 3'b000, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
    exp_issue("flw_iss", 4'd4);
    pres(4'd1, 3'b000, 5'd3, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    exp_issue("int_x3", 4'd1);
    pres(4'd6, 3'b001, 5'd3, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    exp_stall_step("fp_f3");

    // Flush while stalled
    flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("flush_cnt", stall_cycles, exp_stall);
    flush = 1'b0;
    #1;
    exp_stall_step("flush_sb");
    idle();
    mem_done = 1'b1;
    mem_rd = 5'd3;
    mem_fp = 1'b1;
    cyc();
    idle();
    pres(4'd6, 3'b001, 5'd3, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    exp_issue("fp_f3_iss", 4'd6);

    // Reset mid-op
    pres(4'd2, 3'b000, 5'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
    exp_issue("lalu10", 4'd2);
    pres(4'd1, 3'b000, 5'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
    exp_stall_step("waw");
    rst = 1'b1;
    #1;
    chk("rst2_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    idle();
    exp_stall = 0;
    chk("rst2_cnt", stall_cycles, 32'd0);
    lalu_done = 1'b1;
    lalu_rd = 5'd10;
    cyc();
    idle();
    pres(4'd2, 3'b000, 5'd0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
    exp_issue("post_rst", 4'd2);
    pres(4'd1, 3'b000, 5'd11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    exp_stall_step("raw11");
    idle();
    lalu_done = 1'b1;
    lalu_rd = 5'd11;
    cyc();
    idle();

    // I/O: stray done ignored, io_done clears latched dest
    pres(4'd8, 3'b000, 5'd0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
    exp_issue("in_iss", 4'd8);
    idle();
    lalu_done = 1'b1;
    lalu_rd = 5'd12;
    cyc();
    idle();
    pres(4'd1, 3'b000, 5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    exp_stall_step("stray_done");
    idle();
    io_done = 1'b1;
    cyc();
    idle();
    pres(4'd9, 3'b000, 5'd12, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    exp_issue("out_iss", 4'd9);
    pres(4'd8, 3'b000, 5'd0, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    exp_stall_step("io_busy");
    pres(4'd12, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    exp_stall_step("illegal");
    pres(4'd0, 3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    exp_issue("nop", 4'd0);
    idle();
    chk("final_cnt", stall_cycles, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
